// File: rtl/freq_offset_nco.sv
// Carrier-frequency-offset estimator: averages 2^AVG_SHIFT lag-16 correlation phases,
// then runs a wrapped phase accumulator giving one rotation angle per data sample.
module freq_offset_nco #(
  parameter int AVG_SHIFT   = 4,
  parameter int DELAY_SHIFT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic signed [15:0] phase_in,
  input  logic               phase_in_stb,
  input  logic               sample_in_stb,
  output logic signed [15:0] phase_offset,
  output logic               offset_stb,
  output logic signed [15:0] rot_phase,
  output logic               rot_stb,
  output logic               busy
);

  localparam int SUM_W = 16 + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic signed [17:0] ACC_HI   = 18'(1608 << DELAY_SHIFT);
  localparam logic signed [17:0] ACC_SPAN = 18'(3216 << DELAY_SHIFT);

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, TRACK} state_t;

  state_t                    state_q, state_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d, sum_add;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [17:0]        acc_q, acc_d, acc_sub, acc_wrap;
  logic signed [15:0]        phase_offset_q, phase_offset_d;
  logic signed [15:0]        rot_phase_q, rot_phase_d;
  logic                      offset_stb_q, offset_stb_d;
  logic                      rot_stb_q, rot_stb_d;
  logic                      busy_q, busy_d;

  always_comb begin
    sum_add = sum_q + {{AVG_SHIFT{phase_in[15]}}, phase_in};
    acc_sub = acc_q - {{2{phase_offset_q[15]}}, phase_offset_q};
    if (acc_sub >= ACC_HI) begin
      acc_wrap = acc_sub - ACC_SPAN;
    end else if (acc_sub < -ACC_HI) begin
      acc_wrap = acc_sub + ACC_SPAN;
    end else begin
      acc_wrap = acc_sub;
    end
  end

  // With enable low every register holds, so a pending strobe is deferred rather than lost.
  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    phase_offset_d = phase_offset_q;
    rot_phase_d    = rot_phase_q;
    offset_stb_d   = offset_stb_q;
    rot_stb_d      = rot_stb_q;
    busy_d         = busy_q;
    if (enable) begin
      offset_stb_d = 1'b0;
      rot_stb_d    = 1'b0;
      if (start) begin
        sum_d          = '0;
        cnt_d          = '0;
        acc_d          = '0;
        phase_offset_d = '0;
        state_d        = ACCUM;
      end else begin
        case (state_q)
          ACCUM: begin
            if (phase_in_stb) begin
              sum_d = sum_add;
              cnt_d = cnt_q + 1'b1;
              if (cnt_q == LAST_CNT) begin
                phase_offset_d = 16'(sum_add >>> AVG_SHIFT);
                offset_stb_d   = 1'b1;
                state_d        = CALC;
              end
            end
          end
          CALC: begin
            acc_d   = '0;
            state_d = TRACK;
          end
          TRACK: begin
            if (sample_in_stb) begin
              rot_phase_d = 16'(acc_q >>> DELAY_SHIFT);
              rot_stb_d   = 1'b1;
              acc_d       = acc_wrap;
            end
          end
          default: ;
        endcase
      end
      busy_d = (state_d == ACCUM);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      sum_q          <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      phase_offset_q <= '0;
      rot_phase_q    <= '0;
      offset_stb_q   <= 1'b0;
      rot_stb_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      phase_offset_q <= phase_offset_d;
      rot_phase_q    <= rot_phase_d;
      offset_stb_q   <= offset_stb_d;
      rot_stb_q      <= rot_stb_d;
      busy_q         <= busy_d;
    end
  end

  assign phase_offset = phase_offset_q;
  assign rot_phase    = rot_phase_q;
  assign offset_stb   = offset_stb_q & enable;
  assign rot_stb      = rot_stb_q & enable;
  assign busy         = busy_q;

endmodule

// File: tb/tb_freq_offset_nco.sv
// Directed bench for freq_offset_nco with AVG_SHIFT=2; expected values are hand-computed
// (acc steps by -phase_offset per sample, rot_phase = floor(acc_before / 16)).
module tb_freq_offset_nco;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] phase_in = '0;
  logic               phase_in_stb = 1'b0;
  logic               sample_in_stb = 1'b0;
  logic signed [15:0] phase_offset;
  logic               offset_stb;
  logic signed [15:0] rot_phase;
  logic               rot_stb;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  freq_offset_nco #(.AVG_SHIFT(2), .DELAY_SHIFT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .phase_in      (phase_in),
    .phase_in_stb  (phase_in_stb),
    .sample_in_stb (sample_in_stb),
    .phase_offset  (phase_offset),
    .offset_stb    (offset_stb),
    .rot_phase     (rot_phase),
    .rot_stb       (rot_stb),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Four phase strobes; leaves sample_in_stb high during the CALC cycle, where it must be ignored.
  task automatic apply_stimulus(input logic signed [15:0] a, input logic signed [15:0] b,
                                input logic signed [15:0] c, input logic signed [15:0] d,
                                input logic signed [15:0] exp_off, input string tag);
    phase_in_stb = 1'b1;
    phase_in = a; step();
    phase_in = b; step();
    phase_in = c; step();
    check_output({tag, " stb_early"}, offset_stb, 0);
    check_output({tag, " busy_accum"}, busy, 1);
    phase_in = d; step();
    phase_in_stb = 1'b0;
    check_output({tag, " offset_stb"}, offset_stb, 1);
    check_output({tag, " phase_offset"}, phase_offset, exp_off);
    check_output({tag, " busy_drop"}, busy, 0);
    sample_in_stb = 1'b1;
    step();
    check_output({tag, " calc_sample_ignored"}, rot_stb, 0);
    check_output({tag, " offset_pulse_end"}, offset_stb, 0);
  endtask

  task automatic estimate(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [15:0] d,
                          input logic signed [15:0] exp_off, input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, " busy_start"}, busy, 1);
    check_output({tag, " offset_cleared"}, phase_offset, 0);
    apply_stimulus(a, b, c, d, exp_off, tag);
  endtask

  task automatic expect_rot(input int exp, input string tag);
    step();
    check_output({tag, " rot_stb"}, rot_stb, 1);
    check_output({tag, " rot_phase"}, rot_phase, exp);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check_output("rst phase_offset", phase_offset, 0);
    check_output("rst rot_phase", rot_phase, 0);
    check_output("rst offset_stb", offset_stb, 0);
    check_output("rst rot_stb", rot_stb, 0);
    check_output("rst busy", busy, 0);

    phase_in_stb = 1'b1; phase_in = 16'sd300; sample_in_stb = 1'b1;
    step();
    phase_in_stb = 1'b0; sample_in_stb = 1'b0;
    check_output("idle busy", busy, 0);
    check_output("idle rot_stb", rot_stb, 0);
    check_output("idle offset_stb", offset_stb, 0);

    $display("[TB] average of 100s");
    estimate(16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100, "avg100");
    expect_rot(0, "avg100 r1");
    expect_rot(-7, "avg100 r2");
    expect_rot(-13, "avg100 r3");
    sample_in_stb = 1'b0;
    step();
    check_output("avg100 no_stb", rot_stb, 0);
    check_output("avg100 hold", rot_phase, -13);

    $display("[TB] negative floor");
    estimate(-16'sd3, -16'sd2, -16'sd2, -16'sd2, -16'sd3, "neg");
    expect_rot(0, "neg r1");
    expect_rot(0, "neg r2");
    expect_rot(0, "neg r3");
    expect_rot(0, "neg r4");
    expect_rot(0, "neg r5");
    expect_rot(0, "neg r6");
    expect_rot(1, "neg r7");
    sample_in_stb = 1'b0;

    $display("[TB] wrap-around");
    estimate(16'sd1600, 16'sd1600, 16'sd1600, 16'sd1600, 16'sd1600, "wrap");
    for (int j = 1; j <= 16; j++) expect_rot(-100 * (j - 1), $sformatf("wrap r%0d", j));
    expect_rot(-1600, "wrap r17");
    expect_rot(1516, "wrap r18");
    expect_rot(1416, "wrap r19");
    sample_in_stb = 1'b0;

    $display("[TB] restart mid-accumulation");
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart cleared", phase_offset, 0);
    phase_in_stb = 1'b1; phase_in = 16'sd500;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart busy", busy, 1);
    apply_stimulus(16'sd40, 16'sd40, 16'sd40, 16'sd40, 16'sd40, "restart");

    $display("[TB] enable stall");
    expect_rot(0, "stall r1");
    expect_rot(-3, "stall r2");
    step();
    enable = 1'b0;
    #1;
    check_output("stall c1 rot_stb", rot_stb, 0);
    step();
    check_output("stall c2 rot_stb", rot_stb, 0);
    step();
    check_output("stall c3 rot_stb", rot_stb, 0);
    enable = 1'b1;
    #1;
    check_output("stall resume rot_stb", rot_stb, 1);
    check_output("stall resume rot_phase", rot_phase, -5);
    expect_rot(-8, "stall r4");
    expect_rot(-10, "stall r5");

    $display("[TB] reset mid-track");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("rst2 phase_offset", phase_offset, 0);
    check_output("rst2 rot_phase", rot_phase, 0);
    check_output("rst2 rot_stb", rot_stb, 0);
    check_output("rst2 busy", busy, 0);
    step();
    check_output("rst2 idle sample", rot_stb, 0);
    sample_in_stb = 1'b0;

    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check_output("rst over start busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
